// File: rtl/led_pattern_chaser.sv
// led_pattern_chaser
//   LED pattern engine. A prescaler produces a step tick every SHIFT_TIME
//   clocks, and the NUM_LEDS-wide pattern advances once on each tick.
//   Modes: 00 rotate (single-bit chase), 01 fill (Johnson fill/drain),
//   10 bounce (optional), 11 reserved and treated as rotate.
//   Handshake: load is a one-cycle strobe with no ready. It is accepted on
//   the clock edge where it is high, and it beats a coincident tick.
//   Build option: define LED_CHASER_BOUNCE_EN to build bounce mode and its
//   direction register. When it is undefined, mode 10 behaves as rotate.
module led_pattern_chaser #(
   parameter int NUM_LEDS   = 8,
   parameter int SHIFT_TIME = 50000000,
   parameter int CNT_W      = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                dir,
   input  logic [1:0]          mode,
   input  logic                load,
   input  logic [NUM_LEDS-1:0] load_pattern,
   output logic [NUM_LEDS-1:0] led,
   output logic                step
);

   localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(SHIFT_TIME - 1);
   localparam logic [NUM_LEDS-1:0] LED_ONE = NUM_LEDS'(1);

   logic [CNT_W-1:0]    cnt;
   logic                tick;
   logic [NUM_LEDS-1:0] led_nxt;

`ifdef LED_CHASER_BOUNCE_EN
   typedef enum logic {BDIR_UP = 1'b0, BDIR_DOWN = 1'b1} bdir_t;
   bdir_t bdir;
   bdir_t bdir_nxt;
`endif

   // The tick is qualified by enable so that a paused engine never advances.
   assign tick = enable && (cnt == CNT_MAX);

   // Next pattern for the current mode. It is only used in a tick cycle.
   always_comb begin
      led_nxt = led;
`ifdef LED_CHASER_BOUNCE_EN
      bdir_nxt = bdir;
`endif
      case (mode)
         2'b01: begin
            // Johnson fill/drain. An all-zero pattern is a legal state here.
            if (dir)
               led_nxt = {~led[0], led[NUM_LEDS-1:1]};
            else
               led_nxt = {led[NUM_LEDS-2:0], ~led[NUM_LEDS-1]};
         end
`ifdef LED_CHASER_BOUNCE_EN
         2'b10: begin
            if (led == '0) begin
               led_nxt = LED_ONE;
            end else if (bdir == BDIR_UP) begin
               if (led[NUM_LEDS-1]) begin
                  bdir_nxt = BDIR_DOWN;
                  led_nxt  = {1'b0, led[NUM_LEDS-1:1]};
               end else begin
                  led_nxt  = {led[NUM_LEDS-2:0], 1'b0};
               end
            end else begin
               if (led[0]) begin
                  bdir_nxt = BDIR_UP;
                  led_nxt  = {led[NUM_LEDS-2:0], 1'b0};
               end else begin
                  led_nxt  = {1'b0, led[NUM_LEDS-1:1]};
               end
            end
         end
`endif
         default: begin
            // Rotate. Reserved modes land here. A lost bit is recovered as led0.
            if (led == '0)
               led_nxt = LED_ONE;
            else if (dir)
               led_nxt = {led[0], led[NUM_LEDS-1:1]};
            else
               led_nxt = {led[NUM_LEDS-2:0], led[NUM_LEDS-1]};
         end
      endcase
   end

   // Prescaler, pattern register, step pulse and bounce direction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         led  <= LED_ONE;
         step <= 1'b0;
`ifdef LED_CHASER_BOUNCE_EN
         bdir <= BDIR_UP;
`endif
      end else if (load) begin
         cnt  <= '0;
         led  <= load_pattern;
         step <= 1'b0;
      end else if (tick) begin
         cnt  <= '0;
         led  <= led_nxt;
         step <= 1'b1;
`ifdef LED_CHASER_BOUNCE_EN
         bdir <= bdir_nxt;
`endif
      end else if (enable) begin
         cnt  <= cnt + 1'b1;
         step <= 1'b0;
      end else begin
         step <= 1'b0;
      end
   end

endmodule
